// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button front end.
package btn_pkg;

  localparam int BTN_MAX       = 16;
  localparam int DEBOUNCE_10MS = 500000;    // 10 ms at 50 MHz
  localparam int REPEAT_500MS  = 25000000;  // 500 ms at 50 MHz
  localparam int REPEAT_100MS  = 5000000;   // 100 ms at 50 MHz

  // Outcome of one debounce decision for a channel.
  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input longint unsigned value);
    int w;
    w = 0;
    while ((64'd1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, debounced level,
// press/release pulses and, when BTN_AUTOREPEAT_EN is defined, a hold-repeat
// timer that re-issues press pulses while the button stays down.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic clock,
  input  logic anti_reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = clog2(longint'(DEBOUNCE_CYCLES) + 1);
  // The edge commits on the cycle the counter would reach DEBOUNCE_CYCLES,
  // so the stored count never goes past DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  edge_t            edge_kind;
  logic             rpt_fire;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // A level change commits once the mismatch has lasted DEBOUNCE_CYCLES
  always_comb begin
    edge_kind = EDGE_NONE;
    if ((sync_p1 != btn_level) && (cnt == CNT_LAST))
      edge_kind = btn_level ? EDGE_FALL : EDGE_RISE;
  end

  // Debounce counter, debounced level and registered edge pulses
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= (edge_kind == EDGE_RISE) || rpt_fire;
      btn_release <= (edge_kind == EDGE_FALL);
      if (edge_kind != EDGE_NONE) begin
        cnt       <= '0;
        btn_level <= ~btn_level;
      end else if (sync_p1 != btn_level) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = clog2(longint'(RPT_MAX) + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;

  // A release edge suppresses a repeat that falls due on the same cycle
  assign rpt_fire = btn_level && (edge_kind != EDGE_FALL) &&
                    (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));

  // Repeat timer: armed by a debounced rise, counts while the level is high
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else if (edge_kind == EDGE_RISE) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else if (btn_level) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  // Repeat parameters have no effect in this build.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rpt_fire       = 1'b0;
`endif

endmodule

// File: rtl/button_input_ctrl.sv
// Push-button front end: NUM_BTNS debounced channels, sticky press events
// and a priority-encoded selection register that feeds the processor's
// difficulty input. Define BTN_AUTOREPEAT_EN to add hold-to-repeat presses.
module button_input_ctrl
  import btn_pkg::*;
#(
  parameter int                   NUM_BTNS        = 5,
  parameter int                   DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int                   SEL_WIDTH       = 32,
  parameter logic [NUM_BTNS-1:0]  SEL_MASK        = NUM_BTNS'(5'b00111),
  parameter logic [SEL_WIDTH-1:0] SEL_RESET       = '0,
  parameter int                   REPEAT_DELAY    = REPEAT_500MS,
  parameter int                   REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic                 clock,
  input  logic                 anti_reset,
  input  logic [NUM_BTNS-1:0]  btn_raw,
  input  logic [NUM_BTNS-1:0]  evt_clear,
  output logic [NUM_BTNS-1:0]  btn_level,
  output logic [NUM_BTNS-1:0]  btn_press,
  output logic [NUM_BTNS-1:0]  btn_release,
  output logic [NUM_BTNS-1:0]  evt_pending,
  output logic [SEL_WIDTH-1:0] sel_value,
  output logic                 sel_changed
);

  logic [NUM_BTNS-1:0]  sel_hit;
  logic [SEL_WIDTH-1:0] sel_next;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_debounce (
      .clock       (clock),
      .anti_reset  (anti_reset),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

  // Lowest-index masked press wins; no masked press keeps the current value
  always_comb begin
    sel_hit  = btn_press & SEL_MASK;
    sel_next = sel_value;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (sel_hit[i]) sel_next = SEL_WIDTH'(i + 1);
    end
  end

  // Selection register with change pulse
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      sel_value   <= SEL_RESET;
      sel_changed <= 1'b0;
    end else begin
      sel_value   <= sel_next;
      sel_changed <= (sel_next != sel_value);
    end
  end

  // Sticky press events; a press in the same cycle as a clear keeps the flag
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      evt_pending <= '0;
    end else begin
      evt_pending <= (evt_pending & ~evt_clear) | btn_press;
    end
  end

endmodule

// File: tb/tb_button_input_ctrl.sv
// Self-checking bench for button_input_ctrl with a short debounce window.
// Directed scenarios check fixed timing; a randomized run is checked against
// a window-based reference model. Define BTN_AUTOREPEAT_EN for repeat tests.
module tb_button_input_ctrl;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam logic [N-1:0] MASK = 5'b00111;
  localparam logic [31:0]  SRST = 32'd2;

  logic         clock = 1'b0;
  logic         anti_reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] evt_clear = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, evt_pending;
  logic [31:0]  sel_value;
  logic         sel_changed;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [D+1:0] m_hist [N];
  logic [N-1:0] m_level, m_press, m_rel, m_evt;
  logic [31:0]  m_sel;
  logic         m_chg;
  int           m_age [N];

  button_input_ctrl #(
    .NUM_BTNS        (N),
    .DEBOUNCE_CYCLES (D),
    .SEL_WIDTH       (32),
    .SEL_MASK        (MASK),
    .SEL_RESET       (SRST),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clock       (clock),
    .anti_reset  (anti_reset),
    .btn_raw     (btn_raw),
    .evt_clear   (evt_clear),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .evt_pending (evt_pending),
    .sel_value   (sel_value),
    .sel_changed (sel_changed)
  );

  always #5 clock = ~clock;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_hist[i] = '0;
      m_age[i]  = 0;
    end
    m_level = '0; m_press = '0; m_rel = '0; m_evt = '0;
    m_sel = SRST; m_chg = 1'b0;
  endtask

  // Model: the level flips when the last D raw samples (taken two edges
  // back and earlier) all disagree with it.
  task automatic m_step();
    logic [N-1:0] np, nr;
    logic [31:0]  nv;
    bit           flip;
    m_evt = (m_evt & ~evt_clear) | m_press;
    nv = m_sel;
    for (int i = 0; i < N; i++) begin
      if (m_press[i] && MASK[i]) begin
        nv = 32'(i + 1);
        break;
      end
    end
    m_chg = (nv != m_sel);
    m_sel = nv;
    np = '0; nr = '0;
    for (int i = 0; i < N; i++) begin
      m_hist[i] = {m_hist[i][D:0], btn_raw[i]};
      flip = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (m_hist[i][j] == m_level[i]) flip = 1'b0;
      if (flip) begin
        if (m_level[i]) nr[i] = 1'b1;
        else begin
          np[i] = 1'b1;
          m_age[i] = 0;
        end
        m_level[i] = ~m_level[i];
      end
`ifdef BTN_AUTOREPEAT_EN
      else if (m_level[i]) begin
        m_age[i]++;
        if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0)) np[i] = 1'b1;
      end
`endif
    end
    m_press = np;
    m_rel   = nr;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clock or negedge anti_reset);
      if (!anti_reset) m_reset();
      else m_step();
    end
  end

  task automatic test_reset();
    #1 anti_reset = 1'b0;
    #1;
    total++;
    if ({btn_level, btn_press, btn_release, evt_pending, sel_changed} !== '0 || sel_value !== SRST) begin
      bad++;
      $display("FAIL reset_async: lvl=%b prs=%b rel=%b evt=%b sel=%0d chg=%b, want zeros and sel=%0d",
               btn_level, btn_press, btn_release, evt_pending, sel_value, sel_changed, SRST);
    end
    repeat (3) @(negedge clock);
    total++;
    if ({btn_level, btn_press, btn_release, evt_pending, sel_changed} !== '0 || sel_value !== SRST) begin
      bad++;
      $display("FAIL reset_hold: lvl=%b evt=%b sel=%0d, want zeros and sel=%0d",
               btn_level, evt_pending, sel_value, SRST);
    end
    anti_reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_glitch();
    btn_raw[0] = 1'b1;
    repeat (3) @(negedge clock);
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      total++;
      if ({btn_level[0], btn_press[0], evt_pending[0]} !== 3'b000) begin
        bad++;
        $display("FAIL glitch k=%0d: lvl=%b prs=%b evt=%b, want 0 0 0",
                 k, btn_level[0], btn_press[0], evt_pending[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    btn_raw[0] = 1'b1; btn_raw[2] = 1'b1;
    repeat (6) @(negedge clock);
    total++;
    if ({btn_press[2], btn_press[0], btn_level[2], btn_level[0]} !== 4'b1111) begin
      bad++;
      $display("FAIL simul_press: prs=%b lvl=%b, want bits 0 and 2 set", btn_press, btn_level);
    end
    @(negedge clock);
    total++;
    if (sel_value !== 32'd1 || sel_changed !== 1'b1) begin
      bad++;
      $display("FAIL simul_sel: sel=%0d chg=%b, want 1 1", sel_value, sel_changed);
    end
    btn_raw[0] = 1'b0; btn_raw[2] = 1'b0;
    repeat (10) @(negedge clock);
    btn_raw[3] = 1'b1;
    repeat (7) @(negedge clock);
    total++;
    if (sel_value !== 32'd1 || sel_changed !== 1'b0 || evt_pending[3] !== 1'b1) begin
      bad++;
      $display("FAIL unmasked_btn3: sel=%0d chg=%b evt3=%b, want 1 0 1", sel_value, sel_changed, evt_pending[3]);
    end
    btn_raw[3] = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_press_release();
    btn_raw[1] = 1'b1;
    repeat (5) @(negedge clock);
    total++;
    if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0) begin
      bad++;
      $display("FAIL press_early: lvl=%b prs=%b, want 0 0", btn_level[1], btn_press[1]);
    end
    @(negedge clock);
    total++;
    if (btn_level[1] !== 1'b1 || btn_press[1] !== 1'b1) begin
      bad++;
      $display("FAIL press_edge: lvl=%b prs=%b, want 1 1", btn_level[1], btn_press[1]);
    end
    @(negedge clock);
    total++;
    if (sel_value !== 32'd2 || sel_changed !== 1'b1 || btn_press[1] !== 1'b0) begin
      bad++;
      $display("FAIL press_sel: sel=%0d chg=%b prs=%b, want 2 1 0", sel_value, sel_changed, btn_press[1]);
    end
    repeat (5) @(negedge clock);
    btn_raw[1] = 1'b0;
    repeat (5) @(negedge clock);
    total++;
    if (btn_release[1] !== 1'b0 || btn_level[1] !== 1'b1) begin
      bad++;
      $display("FAIL release_early: rel=%b lvl=%b, want 0 1", btn_release[1], btn_level[1]);
    end
    @(negedge clock);
    total++;
    if (btn_release[1] !== 1'b1 || btn_level[1] !== 1'b0) begin
      bad++;
      $display("FAIL release_edge: rel=%b lvl=%b, want 1 0", btn_release[1], btn_level[1]);
    end
    @(negedge clock);
    total++;
    if (btn_release[1] !== 1'b0) begin
      bad++;
      $display("FAIL release_width: rel=%b, want 0", btn_release[1]);
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic test_evt_clear();
    evt_clear = '1;
    @(negedge clock);
    evt_clear = '0;
    total++;
    if (evt_pending !== '0) begin
      bad++;
      $display("FAIL clear_all: evt=%b, want 00000", evt_pending);
    end
    btn_raw[0] = 1'b1;
    repeat (6) @(negedge clock);
    total++;
    if (btn_press[0] !== 1'b1) begin
      bad++;
      $display("FAIL clear_press: prs0=%b, want 1", btn_press[0]);
    end
    evt_clear[0] = 1'b1;
    @(negedge clock);
    total++;
    if (evt_pending[0] !== 1'b1 || sel_value !== 32'd1 || sel_changed !== 1'b1) begin
      bad++;
      $display("FAIL set_wins: evt0=%b sel=%0d chg=%b, want 1 1 1", evt_pending[0], sel_value, sel_changed);
    end
    @(negedge clock);
    evt_clear[0] = 1'b0;
    total++;
    if (evt_pending[0] !== 1'b0) begin
      bad++;
      $display("FAIL clear_alone: evt0=%b, want 0", evt_pending[0]);
    end
    btn_raw[0] = 1'b0;
    repeat (10) @(negedge clock);
    btn_raw[0] = 1'b1;
    repeat (7) @(negedge clock);
    total++;
    if (sel_value !== 32'd1 || sel_changed !== 1'b0 || evt_pending[0] !== 1'b1) begin
      bad++;
      $display("FAIL same_btn_again: sel=%0d chg=%b evt0=%b, want 1 0 1", sel_value, sel_changed, evt_pending[0]);
    end
    btn_raw[0] = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    btn_raw[1] = 1'b1;
    repeat (3) @(negedge clock);
    #2 anti_reset = 1'b0;
    #1;
    total++;
    if ({btn_level, btn_press, btn_release, evt_pending, sel_changed} !== '0 || sel_value !== SRST) begin
      bad++;
      $display("FAIL reset_mid: lvl=%b evt=%b sel=%0d chg=%b, want zeros and sel=%0d",
               btn_level, evt_pending, sel_value, sel_changed, SRST);
    end
    repeat (2) @(negedge clock);
    anti_reset = 1'b1;
    repeat (5) @(negedge clock);
    total++;
    if (btn_press[1] !== 1'b0 || btn_level[1] !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_early: prs=%b lvl=%b, want 0 0", btn_press[1], btn_level[1]);
    end
    @(negedge clock);
    total++;
    if (btn_press[1] !== 1'b1 || btn_level[1] !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_press: prs=%b lvl=%b, want 1 1", btn_press[1], btn_level[1]);
    end
    @(negedge clock);
    total++;
    if (sel_value !== 32'd2 || sel_changed !== 1'b0 || evt_pending[1] !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_sel: sel=%0d chg=%b evt1=%b, want 2 0 1", sel_value, sel_changed, evt_pending[1]);
    end
    btn_raw[1] = 1'b0;
    repeat (10) @(negedge clock);
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int got [$];
    int want [5] = '{6, 26, 34, 42, 50};
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clock);
      if (btn_press[0] === 1'b1) got.push_back(k);
      if (k == 50) btn_raw[0] = 1'b0;
    end
    total++;
    if (got.size() != 5) begin
      bad++;
      $display("FAIL repeat_count: got %0d pulses, want 5", got.size());
    end
    for (int p = 0; p < 5 && p < got.size(); p++) begin
      total++;
      if (got[p] != want[p]) begin
        bad++;
        $display("FAIL repeat_time[%0d]: at %0d, want %0d", p, got[p], want[p]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int hold [N];
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      total++;
      if ({btn_level, btn_press, btn_release, evt_pending, sel_value, sel_changed} !==
          {m_level, m_press, m_rel, m_evt, m_sel, m_chg}) begin
        bad++;
        $display("FAIL random c=%0d: dut lvl=%b prs=%b rel=%b evt=%b sel=%0d chg=%b model lvl=%b prs=%b rel=%b evt=%b sel=%0d chg=%b",
                 c, btn_level, btn_press, btn_release, evt_pending, sel_value, sel_changed,
                 m_level, m_press, m_rel, m_evt, m_sel, m_chg);
      end
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = ($urandom_range(7, 0) == 0) ? int'($urandom_range(45, 20)) : int'($urandom_range(3 * D, 1));
        end else begin
          hold[i]--;
        end
      end
      evt_clear = N'($urandom & $urandom);
    end
    btn_raw = '0;
    evt_clear = '0;
    repeat (20) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_glitch();
    test_simultaneous();
    test_press_release();
    test_evt_clear();
    test_reset_mid();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
